// File: rtl/sha3_pkg.sv
// Shared SHA3 control definitions.
// Holds the sparse squeeze-FSM encoding and its dense decode, the
// multi-bit boolean and life-cycle types, the SW error report struct and
// the REQ/ACK timeout counter width.
package sha3_pkg;

  // Multi-bit boolean: only the exact true code counts as true.
  typedef logic [3:0] mubi4_t;
  localparam mubi4_t MuBi4True  = 4'h6;
  localparam mubi4_t MuBi4False = 4'h9;

  // Life-cycle broadcast signal: anything but the exact off code is on.
  typedef logic [3:0] lc_tx_t;
  localparam lc_tx_t On  = 4'b0101;
  localparam lc_tx_t Off = 4'b1010;

  // Wide enough for AckTimeout values up to 255.
  localparam int unsigned TimeoutCntW = 8;

  typedef enum logic [7:0] {
    ErrNone          = 8'h00,
    ErrSha3SwControl = 8'h80
  } err_code_e;

  typedef struct packed {
    logic      valid;
    err_code_e code;
    logic [23:0] info;
  } err_t;

  // Sparse encoding: every pair of legal codes differs in at least 3 bits,
  // so a single or double upset never lands on another legal state.
  typedef enum logic [5:0] {
    StIdle          = 6'b101100,
    StAbsorb        = 6'b011001,
    StSqueeze       = 6'b110010,
    StAutoRun       = 6'b000111,
    StManualRun     = 6'b111111,
    StFlush         = 6'b010100,
    StTerminalError = 6'b100001
  } sha3_st_sparse_e;

  // Dense view of the FSM state, exported for observation.
  typedef enum logic [2:0] {
    StLIdle          = 3'd0,
    StLAbsorb        = 3'd1,
    StLSqueeze       = 3'd2,
    StLAutoRun       = 3'd3,
    StLManualRun     = 3'd4,
    StLFlush         = 3'd5,
    StLTerminalError = 3'd6
  } sha3_st_e;

  function automatic sha3_st_e sparse2logic(input sha3_st_sparse_e st);
    sha3_st_e res;
    case (st)
      StIdle:      res = StLIdle;
      StAbsorb:    res = StLAbsorb;
      StSqueeze:   res = StLSqueeze;
      StAutoRun:   res = StLAutoRun;
      StManualRun: res = StLManualRun;
      StFlush:     res = StLFlush;
      default:     res = StLTerminalError;
    endcase
    return res;
  endfunction

  function automatic logic mubi4_test_true_strict(input mubi4_t v);
    return v == MuBi4True;
  endfunction

  function automatic logic lc_tx_test_true_loose(input lc_tx_t v);
    return v != Off;
  endfunction

endpackage

// File: rtl/sha3_run_hs.sv
// Keccak run request/grant handshake.
// Ports: run_req_i (request held by the FSM), run_ack_i (grant),
// keccak_run_o (one-cycle trigger on the first granted cycle of a request),
// timeout_hit_o (this cycle is the AckTimeout-th consecutive un-granted one),
// timeout_error_o (sticky copy of timeout_hit_o).
// Handshake: a request stays high until the permutation completes; the
// trigger fires once per request, on the first cycle run_req_i & run_ack_i,
// and re-arms only after run_req_i drops.
module sha3_run_hs
  import sha3_pkg::*;
#(
  parameter int unsigned AckTimeout = 255
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic run_req_i,
  input  logic run_ack_i,
  output logic keccak_run_o,
  output logic timeout_hit_o,
  output logic timeout_error_o
);

  localparam logic [TimeoutCntW-1:0] TimeoutLast = TimeoutCntW'(AckTimeout - 1);
  localparam logic TimeoutEn = (AckTimeout != 0);

  logic                   fired_q;
  logic [TimeoutCntW-1:0] wait_cnt_q;
  logic                   timeout_error_q;

  assign keccak_run_o    = run_req_i & run_ack_i & ~fired_q;
  assign timeout_hit_o   = TimeoutEn & run_req_i & ~run_ack_i & (wait_cnt_q == TimeoutLast);
  assign timeout_error_o = timeout_error_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fired_q         <= 1'b0;
      wait_cnt_q      <= '0;
      timeout_error_q <= 1'b0;
    end else begin
      if (!run_req_i) begin
        fired_q <= 1'b0;
      end else if (run_ack_i) begin
        fired_q <= 1'b1;
      end

      // Counts consecutive un-granted cycles only; a grant restarts it.
      if (TimeoutEn && run_req_i && !run_ack_i) begin
        wait_cnt_q <= wait_cnt_q + 1'b1;
      end else begin
        wait_cnt_q <= '0;
      end

      if (timeout_hit_o) begin
        timeout_error_q <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/sha3_squeeze_ctrl.sv
// SHA3 squeeze controller: sequences start/absorb, auto-squeezes up to
// nblocks digest blocks (one Keccak run between blocks), then hands control
// to SW for manual runs or the final done.
// Ports: start_i/process_i/run_i/done_i SW controls; nblocks_i block count
// sampled at start; keccak_* to the pad/core; absorbed_i/keccak_complete_i
// from the core; run_req_o/run_ack_i run handshake; block_valid_o/
// block_ready_i digest block stream; state_valid_o, blocks_left_o, error_o,
// sparse_fsm_error_o, timeout_error_o status; state_o dense FSM state.
// Block stream: a block transfers on a cycle with block_valid_o & block_ready_i.
module sha3_squeeze_ctrl
  import sha3_pkg::*;
#(
  parameter  int unsigned MaxBlocks  = 16,
  parameter  int unsigned AckTimeout = 255,
  localparam int unsigned CntW       = $clog2(MaxBlocks + 1)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            start_i,
  input  logic            process_i,
  input  logic            run_i,
  input  mubi4_t          done_i,
  input  logic [CntW-1:0] nblocks_i,
  input  lc_tx_t          lc_escalate_en_i,
  output logic            keccak_start_o,
  output logic            keccak_process_o,
  output mubi4_t          keccak_done_o,
  input  mubi4_t          absorbed_i,
  input  logic            keccak_complete_i,
  output logic            run_req_o,
  input  logic            run_ack_i,
  output logic            keccak_run_o,
  output logic            block_valid_o,
  input  logic            block_ready_i,
  output logic            state_valid_o,
  output logic [CntW-1:0] blocks_left_o,
  output err_t            error_o,
  output logic            sparse_fsm_error_o,
  output logic            timeout_error_o,
  output sha3_st_e        state_o
);

  sha3_st_sparse_e state_q;
  logic [CntW-1:0] cnt_q;
  logic            processing_q;
  logic            start_q, process_q;
  mubi4_t          done_q;
  err_t            err_q;

  logic done_req, escalate, timeout_hit, sw_err;

  assign done_req = mubi4_test_true_strict(done_i);
  assign escalate = lc_tx_test_true_loose(lc_escalate_en_i);

  assign run_req_o          = (state_q == StAutoRun) || (state_q == StManualRun);
  assign state_valid_o      = (state_q == StSqueeze);
  assign block_valid_o      = (state_q == StSqueeze) && (cnt_q != '0);
  assign sparse_fsm_error_o = (state_q == StTerminalError);
  assign blocks_left_o      = cnt_q;
  assign keccak_start_o     = start_q;
  assign keccak_process_o   = process_q;
  assign keccak_done_o      = done_q;
  assign error_o            = err_q;
  assign state_o            = sparse2logic(state_q);

  sha3_run_hs #(
    .AckTimeout(AckTimeout)
  ) u_run_hs (
    .clk_i,
    .rst_ni,
    .run_req_i      (run_req_o),
    .run_ack_i,
    .keccak_run_o,
    .timeout_hit_o  (timeout_hit),
    .timeout_error_o
  );

  // Control inputs arriving where the current state does not accept them.
  always_comb begin
    sw_err = 1'b0;
    case (state_q)
      StIdle:      sw_err = process_i | run_i | done_req;
      StAbsorb:    sw_err = start_i | run_i | done_req | (process_i & processing_q);
      StSqueeze:   sw_err = start_i | process_i | ((cnt_q != '0) & (run_i | done_req));
      StAutoRun,
      StManualRun,
      StFlush:     sw_err = start_i | process_i | run_i | done_req;
      default:     sw_err = 1'b0;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      processing_q <= 1'b0;
      start_q      <= 1'b0;
      process_q    <= 1'b0;
      done_q       <= MuBi4False;
      err_q        <= '{valid: 1'b0, code: ErrNone, info: '0};
    end else begin
      start_q   <= 1'b0;
      process_q <= 1'b0;
      done_q    <= MuBi4False;
      err_q     <= '{valid: sw_err, code: ErrSha3SwControl,
                     info: 24'({done_req, run_i, process_i, start_i})};

      case (state_q)
        StIdle: begin
          if (start_i) begin
            state_q      <= StAbsorb;
            start_q      <= 1'b1;
            processing_q <= 1'b0;
            cnt_q        <= (nblocks_i > CntW'(MaxBlocks)) ? CntW'(MaxBlocks) : nblocks_i;
          end
        end
        StAbsorb: begin
          if (process_i && !processing_q) begin
            process_q    <= 1'b1;
            processing_q <= 1'b1;
          end
          if (mubi4_test_true_strict(absorbed_i)) begin
            state_q      <= StSqueeze;
            processing_q <= 1'b0;
          end
        end
        StSqueeze: begin
          // The block handshake outranks SW run/done requests.
          if (block_valid_o && block_ready_i) begin
            cnt_q <= cnt_q - CntW'(1);
            if (cnt_q != CntW'(1)) begin
              state_q <= StAutoRun;
            end
          end else if (cnt_q == '0) begin
            if (run_i) begin
              state_q <= StManualRun;
            end else if (done_req) begin
              state_q <= StFlush;
              done_q  <= done_i;
            end
          end
        end
        StAutoRun, StManualRun: begin
          if (keccak_complete_i) begin
            state_q <= StSqueeze;
          end
        end
        StFlush: begin
          state_q      <= StIdle;
          cnt_q        <= '0;
          processing_q <= 1'b0;
        end
        StTerminalError: state_q <= StTerminalError;
        default:         state_q <= StTerminalError;
      endcase

      if (timeout_hit) begin
        state_q <= StTerminalError;
      end

      if (escalate) begin
        state_q   <= StTerminalError;
        start_q   <= 1'b0;
        process_q <= 1'b0;
        done_q    <= MuBi4False;
      end
    end
  end

endmodule

// File: tb/tb_sha3_squeeze_ctrl.sv
module tb_sha3_squeeze_ctrl;
  import sha3_pkg::*;

  localparam int unsigned MaxBlocks  = 16;
  localparam int unsigned AckTimeout = 8;
  localparam int unsigned CntW       = $clog2(MaxBlocks + 1);

  localparam logic [2:0] SIdle = 3'd0, SAbsorb = 3'd1, SSqueeze = 3'd2,
                         SAutoRun = 3'd3, SManualRun = 3'd4, SFlush = 3'd5,
                         STermErr = 3'd6;

  // ---------------- clock / reset ----------------
  logic clk_i = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk_i = ~clk_i;

  logic            start_i = 1'b0, process_i = 1'b0, run_i = 1'b0;
  mubi4_t          done_i = MuBi4False;
  logic [CntW-1:0] nblocks_i = '0;
  lc_tx_t          lc_escalate_en_i = Off;
  logic            keccak_start_o, keccak_process_o;
  mubi4_t          keccak_done_o;
  mubi4_t          absorbed_i = MuBi4False;
  logic            keccak_complete_i = 1'b0;
  logic            run_req_o, run_ack_i = 1'b0, keccak_run_o;
  logic            block_valid_o, block_ready_i = 1'b0;
  logic            state_valid_o;
  logic [CntW-1:0] blocks_left_o;
  err_t            error_o;
  logic            sparse_fsm_error_o, timeout_error_o;
  sha3_st_e        state_o;

  sha3_squeeze_ctrl #(
    .MaxBlocks (MaxBlocks),
    .AckTimeout(AckTimeout)
  ) dut (
    .clk_i             (clk_i),
    .rst_ni            (rst_ni),
    .start_i           (start_i),
    .process_i         (process_i),
    .run_i             (run_i),
    .done_i            (done_i),
    .nblocks_i         (nblocks_i),
    .lc_escalate_en_i  (lc_escalate_en_i),
    .keccak_start_o    (keccak_start_o),
    .keccak_process_o  (keccak_process_o),
    .keccak_done_o     (keccak_done_o),
    .absorbed_i        (absorbed_i),
    .keccak_complete_i (keccak_complete_i),
    .run_req_o         (run_req_o),
    .run_ack_i         (run_ack_i),
    .keccak_run_o      (keccak_run_o),
    .block_valid_o     (block_valid_o),
    .block_ready_i     (block_ready_i),
    .state_valid_o     (state_valid_o),
    .blocks_left_o     (blocks_left_o),
    .error_o           (error_o),
    .sparse_fsm_error_o(sparse_fsm_error_o),
    .timeout_error_o   (timeout_error_o),
    .state_o           (state_o)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  int run_pulses = 0;
  logic [CntW-1:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Each block handshake pops the blocks_left value expected at that moment.
  always @(negedge clk_i) begin
    if (rst_ni) begin
      if (keccak_run_o) run_pulses++;
      if (block_valid_o && block_ready_i) begin
        checks++;
        assert (exp_q.size() != 0) else begin
          errors++;
          $error("FAIL unexpected_block: observed blocks_left %0d expected no handshake", blocks_left_o);
        end
        if (exp_q.size() != 0) begin
          logic [CntW-1:0] e;
          e = exp_q.pop_front();
          checks++;
          assert (blocks_left_o === e) else begin
            errors++;
            $error("FAIL block_left_at_handshake: observed %0d expected %0d", blocks_left_o, e);
          end
        end
      end
    end
  end

  // Keccak core model: completes two cycles after each trigger.
  always begin
    @(negedge clk_i);
    if (keccak_run_o) begin
      @(posedge clk_i); #1;
      @(posedge clk_i); #1;
      keccak_complete_i = 1'b1;
      @(posedge clk_i); #1;
      keccak_complete_i = 1'b0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no end of test expected finish before 200000");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic cyc(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    cyc(2);
    exp_q.delete();
    rst_ni = 1'b1;
    cyc(1);
  endtask

  task automatic wait_state(input string tag, input logic [2:0] s, input int budget);
    for (int i = 0; i < budget && state_o != s; i++) cyc(1);
    chk(tag, 32'(state_o), 32'(s));
  endtask

  // start -> process -> absorbed, ending in Squeeze.
  task automatic run_absorb(input logic [CntW-1:0] nb, input logic [CntW-1:0] exp_cnt);
    nblocks_i = nb;
    start_i = 1'b1;
    cyc(1);
    start_i = 1'b0;
    chk("start_pulse", 32'(keccak_start_o), 1);
    chk("absorb_state", 32'(state_o), 32'(SAbsorb));
    chk("cnt_loaded", 32'(blocks_left_o), 32'(exp_cnt));
    process_i = 1'b1;
    cyc(1);
    process_i = 1'b0;
    chk("process_pulse", 32'(keccak_process_o), 1);
    absorbed_i = MuBi4True;
    cyc(1);
    absorbed_i = MuBi4False;
    chk("squeeze_state", 32'(state_o), 32'(SSqueeze));
    chk("state_valid", 32'(state_valid_o), 1);
  endtask

  task automatic finish_hash();
    done_i = MuBi4True;
    cyc(1);
    done_i = MuBi4False;
    chk("flush_state", 32'(state_o), 32'(SFlush));
    chk("done_out", 32'(keccak_done_o), 32'(MuBi4True));
    cyc(1);
    chk("idle_after_flush", 32'(state_o), 32'(SIdle));
    chk("cnt_cleared", 32'(blocks_left_o), 0);
  endtask

  // ---------------- directed sequence ----------------
  int base;

  initial begin
    // Reset values
    cyc(1);
    chk("rst_state", 32'(state_o), 32'(SIdle));
    chk("rst_run_req", 32'(run_req_o), 0);
    chk("rst_cnt", 32'(blocks_left_o), 0);
    chk("rst_done", 32'(keccak_done_o), 32'(MuBi4False));
    chk("rst_err_valid", 32'(error_o.valid), 0);
    chk("rst_timeout", 32'(timeout_error_o), 0);
    rst_ni = 1'b1;
    cyc(1);

    // Three auto blocks, consumer always ready, two runs in between
    run_ack_i = 1'b1;
    run_absorb(3, 3);
    chk("block_valid_3", 32'(block_valid_o), 1);
    base = run_pulses;
    exp_q.push_back(3); exp_q.push_back(2); exp_q.push_back(1);
    block_ready_i = 1'b1;
    for (int i = 0; i < 60 && exp_q.size() != 0; i++) cyc(1);
    chk("drain_3", 32'(exp_q.size()), 0);
    cyc(1);
    block_ready_i = 1'b0;
    chk("runs_3", 32'(run_pulses - base), 2);
    chk("cnt_zero_3", 32'(blocks_left_o), 0);
    chk("block_valid_off", 32'(block_valid_o), 0);
    chk("squeeze_after_3", 32'(state_o), 32'(SSqueeze));
    finish_hash();

    // Zero blocks, one manual run, then done
    run_absorb(0, 0);
    chk("block_valid_0", 32'(block_valid_o), 0);
    base = run_pulses;
    run_i = 1'b1;
    cyc(1);
    run_i = 1'b0;
    chk("manual_state", 32'(state_o), 32'(SManualRun));
    chk("manual_req", 32'(run_req_o), 1);
    chk("manual_no_err", 32'(error_o.valid), 0);
    wait_state("manual_back", SSqueeze, 20);
    chk("manual_runs", 32'(run_pulses - base), 1);
    finish_hash();

    // run_i while blocks remain, then run_i racing a block handshake
    run_absorb(2, 2);
    run_i = 1'b1;
    cyc(1);
    run_i = 1'b0;
    chk("early_run_err", 32'(error_o.valid), 1);
    chk("early_run_code", 32'(error_o.code), 32'(ErrSha3SwControl));
    chk("early_run_info", 32'(error_o.info), 32'h4);
    chk("early_run_noreq", 32'(run_req_o), 0);
    chk("early_run_state", 32'(state_o), 32'(SSqueeze));
    exp_q.push_back(2); exp_q.push_back(1);
    block_ready_i = 1'b1;
    run_i = 1'b1;
    cyc(1);
    run_i = 1'b0;
    chk("race_state", 32'(state_o), 32'(SAutoRun));
    chk("race_err_info", 32'(error_o.info), 32'h4);
    chk("race_err_valid", 32'(error_o.valid), 1);
    chk("race_cnt", 32'(blocks_left_o), 1);
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) cyc(1);
    chk("drain_2", 32'(exp_q.size()), 0);
    cyc(1);
    block_ready_i = 1'b0;
    finish_hash();

    // Clamp, duplicate process, escalation during AutoRun
    nblocks_i = 20;
    start_i = 1'b1;
    cyc(1);
    start_i = 1'b0;
    chk("clamp_cnt", 32'(blocks_left_o), 32'(MaxBlocks));
    process_i = 1'b1;
    cyc(1);
    chk("first_process", 32'(keccak_process_o), 1);
    cyc(1);
    process_i = 1'b0;
    chk("dup_process_pulse", 32'(keccak_process_o), 0);
    chk("dup_process_err", 32'(error_o.valid), 1);
    chk("dup_process_info", 32'(error_o.info), 32'h2);
    absorbed_i = MuBi4True;
    cyc(1);
    absorbed_i = MuBi4False;
    chk("clamp_squeeze", 32'(state_o), 32'(SSqueeze));
    run_ack_i = 1'b0;
    exp_q.push_back(16);
    block_ready_i = 1'b1;
    cyc(1);
    block_ready_i = 1'b0;
    chk("esc_autorun", 32'(state_o), 32'(SAutoRun));
    chk("esc_req_before", 32'(run_req_o), 1);
    lc_escalate_en_i = On;
    cyc(1);
    chk("esc_state", 32'(state_o), 32'(STermErr));
    chk("esc_req", 32'(run_req_o), 0);
    chk("esc_state_valid", 32'(state_valid_o), 0);
    chk("esc_sparse", 32'(sparse_fsm_error_o), 1);
    lc_escalate_en_i = Off;
    cyc(2);
    chk("term_absorbing", 32'(state_o), 32'(STermErr));
    do_reset();

    // ACK timeout
    run_absorb(2, 2);
    run_ack_i = 1'b0;
    exp_q.push_back(2);
    block_ready_i = 1'b1;
    cyc(1);
    block_ready_i = 1'b0;
    chk("to_autorun", 32'(state_o), 32'(SAutoRun));
    cyc(AckTimeout - 1);
    chk("to_not_yet", 32'(timeout_error_o), 0);
    chk("to_still_run", 32'(state_o), 32'(SAutoRun));
    cyc(1);
    chk("to_flag", 32'(timeout_error_o), 1);
    chk("to_state", 32'(state_o), 32'(STermErr));
    chk("to_sparse", 32'(sparse_fsm_error_o), 1);
    do_reset();
    chk("to_cleared", 32'(timeout_error_o), 0);

    // Reset mid-run: request drops at once, no trigger afterwards
    run_absorb(2, 2);
    exp_q.push_back(2);
    block_ready_i = 1'b1;
    cyc(1);
    block_ready_i = 1'b0;
    cyc(2);
    chk("mid_req_high", 32'(run_req_o), 1);
    #2 rst_ni = 1'b0;
    #1;
    chk("async_req_drop", 32'(run_req_o), 0);
    exp_q.delete();
    base = run_pulses;
    run_ack_i = 1'b1;
    cyc(2);
    rst_ni = 1'b1;
    cyc(6);
    chk("no_run_after_rst", 32'(run_pulses - base), 0);
    chk("idle_after_rst", 32'(state_o), 32'(SIdle));

    // Random-length hash as a final sweep
    begin
      logic [CntW-1:0] nb;
      nb = CntW'($urandom_range(1, 5));
      run_absorb(nb, nb);
      base = run_pulses;
      for (int k = int'(nb); k >= 1; k--) exp_q.push_back(CntW'(k));
      block_ready_i = 1'b1;
      for (int i = 0; i < 100 && exp_q.size() != 0; i++) cyc(1);
      chk("drain_rand", 32'(exp_q.size()), 0);
      cyc(1);
      block_ready_i = 1'b0;
      chk("runs_rand", 32'(run_pulses - base), 32'(nb) - 1);
      finish_hash();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sha3_squeeze_ctrl.md
SHA3_SQUEEZE_CTRL -- requirements
Module: sha3_squeeze_ctrl

Interface
REQ-001 Parameter MaxBlocks, default 16: maximum number of auto-squeezed blocks per hash; range 1..255.
REQ-002 Parameter AckTimeout, default 255: maximum cycles run_req_o may stay un-ACKed; 0 disables the check.
REQ-003 Derived localparam CntW = $clog2(MaxBlocks+1).
REQ-004 Clock and reset: clk_i  in  1  clock; rst_ni  in  1  reset, asynchronous, active-low.
REQ-005 Control inputs: start_i  in  1  begin hash; process_i  in  1  final absorb; run_i  in  1  SW manual Keccak run; done_i  in  mubi4_t  end hash; nblocks_i  in  CntW  number of blocks to auto-emit, sampled at start.
REQ-006 Escalation input: lc_escalate_en_i  in  lc_tx_t  life-cycle escalation.
REQ-007 Core outputs: keccak_start_o, keccak_process_o  out  1  pulses to pad; keccak_done_o  out  mubi4_t  to pad and round clear.
REQ-008 Core inputs: absorbed_i  in  mubi4_t  absorb complete; keccak_complete_i  in  1  Keccak permutation finished.
REQ-009 Run handshake: run_req_o  out  1  request; run_ack_i  in  1  grant; keccak_run_o  out  1  single-cycle permutation trigger.
REQ-010 Block stream: block_valid_o  out  1  digest block available; block_ready_i  in  1  consumer took block.
REQ-011 Status: state_valid_o  out  1  state may be exposed; blocks_left_o  out  CntW  remaining auto blocks; error_o  out  err_t  SW-control error; sparse_fsm_error_o  out  1; timeout_error_o  out  1  sticky.

Function
REQ-012 FSM states: Idle, Absorb, Squeeze, AutoRun, ManualRun, Flush, TerminalError; sparse encoding, any illegal code -> TerminalError.
REQ-013 Idle: start_i -> Absorb, keccak_start_o=1 that cycle, blocks counter loaded with min(nblocks_i, MaxBlocks).
REQ-014 Absorb: process_i with processing flag clear -> keccak_process_o=1 and flag set; mubi4 strict-true absorbed_i -> Squeeze, flag cleared.
REQ-015 Squeeze: state_valid_o=1; block_valid_o=1 iff counter!=0.
REQ-016 Squeeze, block_valid_o & block_ready_i: counter decrements; if new value !=0 -> AutoRun, else stay in Squeeze.
REQ-017 AutoRun and ManualRun: run_req_o asserted from entry until keccak_complete_i; keccak_run_o pulses in the first cycle with run_req_o & run_ack_i only; keccak_complete_i -> Squeeze.
REQ-018 Squeeze with counter==0: run_i -> ManualRun; strict-true done_i -> Flush with keccak_done_o=done_i; run_i has priority over done_i.
REQ-019 Squeeze with counter!=0: run_i and done_i ignored and flagged via error_o.
REQ-020 Flush -> Idle after one cycle; counter cleared.
REQ-021 error_o.valid with code ErrSha3SwControl, info = {done_i, run_i, process_i, start_i} zero-extended, when any of the following holds:
  - a control input arrives in a state not accepting it;
  - a duplicate process_i arrives;
  - run_i or done_i arrives in Squeeze with counter!=0.
REQ-022 Timeout: when AckTimeout!=0, count consecutive cycles of run_req_o & ~run_ack_i; on reaching AckTimeout, set timeout_error_o sticky and enter TerminalError.
REQ-023 lc_escalate_en_i loose-true: next state TerminalError from any state, overriding all transitions.
REQ-024 TerminalError: absorbing; sparse_fsm_error_o=1; all pulses, run_req_o, block_valid_o and state_valid_o held 0.
REQ-025 Simultaneous block_ready_i and run_i in Squeeze: block handshake wins; run_i is flagged as an error.

Reset
REQ-026 Reset values: FSM Idle; counter 0; processing 0; run_req_o 0; keccak_run_o 0; timeout_error_o 0; keccak_done_o MuBi4False; error_o valid 0.
REQ-027 Reset asserted mid-run drops run_req_o asynchronously; no keccak_run_o after reset release without a new start_i.

Structure
REQ-028 The sparse state enum, its sparse2logic function and the timeout counter width belong in sha3_pkg; err_t and ErrSha3SwControl are reused from that package.
REQ-029 One sub-module, sha3_run_hs, holds the REQ/ACK, single-pulse trigger and timeout counter; the FSM stays in the top.

Verification
REQ-030 nblocks_i=3, start, process, absorbed; consumer ready every cycle -> 3 block_valid_o handshakes, exactly 2 keccak_run_o pulses, blocks_left_o reaches 0.
REQ-031 nblocks_i=0, start, process, absorbed, run_i -> one keccak_run_o, return to Squeeze on complete; done_i=MuBi4True -> Flush then Idle.
REQ-032 Squeeze with counter=2, run_i pulse -> error_o.valid=1, info=4'b0100, no run_req_o.
REQ-033 AckTimeout=8, run_ack_i held 0 -> timeout_error_o=1 after the 8th un-ACKed cycle, FSM in TerminalError, sparse_fsm_error_o=1.
REQ-034 lc_escalate_en_i=On during AutoRun -> TerminalError next cycle, run_req_o=0, state_valid_o=0.
REQ-035 Duplicate process_i in Absorb -> error_o.valid=1, info=4'b0010, keccak_process_o not pulsed.
